// File: rtl/retry_dmr_stage_pkg.sv
// ============================================================================
// Module      : retry_dmr_stage_pkg
// Description : Shared defaults for the DMR retry pipeline stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package retry_dmr_stage_pkg;

   localparam int unsigned DEFAULT_ID_SIZE   = 2;
   localparam int unsigned DEFAULT_DEPTH     = 2;
   localparam int unsigned DEFAULT_CNT_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/retry_dmr_pipe_reg.sv
// ============================================================================
// Module      : retry_dmr_pipe_reg
// Description : One elastic stage holding a shared valid and A/B data/id copies.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module retry_dmr_pipe_reg
   import retry_dmr_stage_pkg::*;
#(
   parameter type         DataType = logic [7:0],
   parameter int unsigned ID_SIZE  = DEFAULT_ID_SIZE
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               adv,
   input  logic               in_valid,
   input  DataType            in_data_a,
   input  DataType            in_data_b,
   input  logic [ID_SIZE-1:0] in_id_a,
   input  logic [ID_SIZE-1:0] in_id_b,
   output logic               valid,
   output DataType            data_a,
   output DataType            data_b,
   output logic [ID_SIZE-1:0] id_a,
   output logic [ID_SIZE-1:0] id_b
);

   logic               r_valid;
   DataType            r_data_a;
   DataType            r_data_b;
   logic [ID_SIZE-1:0] r_id_a;
   logic [ID_SIZE-1:0] r_id_b;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
      end else if (adv) begin
         r_valid <= in_valid;
      end
   end

   // The two copies live in separate processes so no register is ever shared.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data_a <= '0;
         r_id_a   <= '0;
      end else if (adv && in_valid) begin
         r_data_a <= in_data_a;
         r_id_a   <= in_id_a;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data_b <= '0;
         r_id_b   <= '0;
      end else if (adv && in_valid) begin
         r_data_b <= in_data_b;
         r_id_b   <= in_id_b;
      end
   end

   assign valid  = r_valid;
   assign data_a = r_data_a;
   assign data_b = r_data_b;
   assign id_a   = r_id_a;
   assign id_b   = r_id_b;

endmodule

`default_nettype wire

// File: rtl/retry_dmr_stage.sv
// ============================================================================
// Module      : retry_dmr_stage
// Description : DMR pipelined stage with output copy compare and fault counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module retry_dmr_stage
   import retry_dmr_stage_pkg::*;
#(
   parameter type         DataType = logic [7:0],
   parameter int unsigned ID_SIZE  = DEFAULT_ID_SIZE,
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter int unsigned CntWidth = DEFAULT_CNT_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  DataType             data_i,
   input  logic [ID_SIZE-1:0]  id_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic                inject_fault_i,
   output DataType             data_o,
   output logic [ID_SIZE-1:0]  id_o,
   output logic                faulty_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [CntWidth-1:0] fault_cnt_o
);

   // Index 0 is the upstream interface; index s+1 is the output of stage s.
   logic [DEPTH:0]     w_valid;
   logic [DEPTH-1:0]   w_adv;
   DataType            w_data_a [DEPTH+1];
   DataType            w_data_b [DEPTH+1];
   logic [ID_SIZE-1:0] w_id_a   [DEPTH+1];
   logic [ID_SIZE-1:0] w_id_b   [DEPTH+1];
   logic               w_out_hs;
   logic [CntWidth-1:0] r_fault_cnt;

   assign w_valid[0]  = valid_i;
   assign w_data_a[0] = data_i;
   assign w_data_b[0] = data_i ^ DataType'(inject_fault_i);
   assign w_id_a[0]   = id_i;
   assign w_id_b[0]   = id_i;

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      // Unrolled advance chain: a stage moves if ready_i or any later stage is empty.
      assign w_adv[s] = ready_i || !(&w_valid[DEPTH:s+1]);

      retry_dmr_pipe_reg #(
         .DataType (DataType),
         .ID_SIZE  (ID_SIZE)
      ) u_pipe_reg (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .adv       (w_adv[s]),
         .in_valid  (w_valid[s]),
         .in_data_a (w_data_a[s]),
         .in_data_b (w_data_b[s]),
         .in_id_a   (w_id_a[s]),
         .in_id_b   (w_id_b[s]),
         .valid     (w_valid[s+1]),
         .data_a    (w_data_a[s+1]),
         .data_b    (w_data_b[s+1]),
         .id_a      (w_id_a[s+1]),
         .id_b      (w_id_b[s+1])
      );
   end

   assign ready_o  = w_adv[0];
   assign valid_o  = w_valid[DEPTH];
   assign data_o   = w_data_a[DEPTH];
   assign id_o     = w_id_a[DEPTH];
   assign faulty_o = w_valid[DEPTH] &&
                     ((w_data_a[DEPTH] != w_data_b[DEPTH]) || (w_id_a[DEPTH] != w_id_b[DEPTH]));
   assign w_out_hs = valid_o && ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fault_cnt <= '0;
      end else if (w_out_hs && faulty_o && (r_fault_cnt != '1)) begin
         r_fault_cnt <= r_fault_cnt + CntWidth'(1);
      end
   end

   assign fault_cnt_o = r_fault_cnt;

endmodule

`default_nettype wire

// File: tb/tb_retry_dmr_stage.sv
// ============================================================================
// Module      : tb_retry_dmr_stage
// Description : Directed self-checking bench for retry_dmr_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_retry_dmr_stage;

   localparam int DEPTH = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [7:0]  data_i;
   logic [1:0]  id_i;
   logic        valid_i;
   logic        inject_fault_i;
   logic        ready_i;
   logic        ready_o;
   logic [7:0]  data_o;
   logic [1:0]  id_o;
   logic        faulty_o;
   logic        valid_o;
   logic [15:0] fault_cnt_o;

   logic        sat_ready_o;
   logic [7:0]  sat_data_o;
   logic [1:0]  sat_id_o;
   logic        sat_faulty_o;
   logic        sat_valid_o;
   logic [1:0]  sat_fault_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   retry_dmr_stage #(
      .DataType (logic [7:0]),
      .ID_SIZE  (2),
      .DEPTH    (DEPTH),
      .CntWidth (16)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .data_i         (data_i),
      .id_i           (id_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .inject_fault_i (inject_fault_i),
      .data_o         (data_o),
      .id_o           (id_o),
      .faulty_o       (faulty_o),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .fault_cnt_o    (fault_cnt_o)
   );

   retry_dmr_stage #(
      .DataType (logic [7:0]),
      .ID_SIZE  (2),
      .DEPTH    (DEPTH),
      .CntWidth (2)
   ) dut_sat (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .data_i         (data_i),
      .id_i           (id_i),
      .valid_i        (valid_i),
      .ready_o        (sat_ready_o),
      .inject_fault_i (inject_fault_i),
      .data_o         (sat_data_o),
      .id_o           (sat_id_o),
      .faulty_o       (sat_faulty_o),
      .valid_o        (sat_valid_o),
      .ready_i        (ready_i),
      .fault_cnt_o    (sat_fault_cnt_o)
   );

   task automatic test_reset();
      int seen;
      rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; inject_fault_i = 1'b0;
      data_i = 8'h00; id_i = 2'd0;
      repeat (10) @(negedge clk_i);
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready_o); end
      checks++; if (fault_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", fault_cnt_o); end
      checks++; if (faulty_o !== 1'b0) begin errors++; $display("FAIL rst_faulty got %b exp 0", faulty_o); end
      checks++; if (data_o !== 8'h00 || id_o !== 2'd0) begin errors++; $display("FAIL rst_data got %h/%0d exp 00/0", data_o, id_o); end
      rst_ni = 1'b1;
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rel_state got v%b r%b exp v0 r1", valid_o, ready_o); end
      // two beats in flight, then reset mid-operation
      ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h11;
      @(negedge clk_i);
      data_i = 8'h22;
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin errors++; $display("FAIL inflight got v%b %h exp v1 11", valid_o, data_o); end
      rst_ni = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL async_rst got %b exp 0", valid_o); end
      @(negedge clk_i);
      rst_ni = 1'b1; ready_i = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk_i);
         if (valid_o) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_drop got %0d beats exp 0", seen); end
   endtask

   task automatic test_latency();
      ready_i = 1'b1; valid_i = 1'b1; data_i = 8'hA5; id_i = 2'd1; inject_fault_i = 1'b0;
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", valid_o); end
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", valid_o); end
      checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL lat_data got %h exp a5", data_o); end
      checks++; if (id_o !== 2'd1) begin errors++; $display("FAIL lat_id got %0d exp 1", id_o); end
      checks++; if (faulty_o !== 1'b0) begin errors++; $display("FAIL lat_faulty got %b exp 0", faulty_o); end
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lat_drain got %b exp 0", valid_o); end
   endtask

   task automatic test_injection();
      ready_i = 1'b1; valid_i = 1'b1; data_i = 8'h3C; id_i = 2'd2; inject_fault_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0; inject_fault_i = 1'b0; ready_i = 1'b0;
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b1 || data_o !== 8'h3C) begin errors++; $display("FAIL inj_data got v%b %h exp v1 3c", valid_o, data_o); end
      checks++; if (id_o !== 2'd2) begin errors++; $display("FAIL inj_id got %0d exp 2", id_o); end
      checks++; if (faulty_o !== 1'b1) begin errors++; $display("FAIL inj_faulty got %b exp 1", faulty_o); end
      @(negedge clk_i);
      checks++; if (faulty_o !== 1'b1 || data_o !== 8'h3C) begin errors++; $display("FAIL inj_hold got f%b %h exp f1 3c", faulty_o, data_o); end
      checks++; if (fault_cnt_o !== 16'd0) begin errors++; $display("FAIL inj_cnt_pre got %0d exp 0", fault_cnt_o); end
      ready_i = 1'b1;
      @(negedge clk_i);
      checks++; if (fault_cnt_o !== 16'd1) begin errors++; $display("FAIL inj_cnt got %0d exp 1", fault_cnt_o); end
      checks++; if (valid_o !== 1'b0 || faulty_o !== 1'b0) begin errors++; $display("FAIL inj_after got v%b f%b exp v0 f0", valid_o, faulty_o); end
   endtask

   task automatic test_backpressure();
      logic [31:0] pat;
      logic        r, mv0, mv1, adv0, adv1, exp_rdy;
      logic [7:0]  md0, md1;
      int          sent, rcvd;
      pat = 32'hC53A_6C91;
      mv0 = 1'b0; mv1 = 1'b0; md0 = 8'h00; md1 = 8'h00;
      sent = 0; rcvd = 0;
      inject_fault_i = 1'b0;
      for (int cyc = 0; cyc < 200 && rcvd < 16; cyc++) begin
         r = pat[cyc % 32];
         ready_i = r;
         valid_i = (sent < 16);
         data_i  = sent[7:0];
         id_i    = sent[1:0];
         #1;
         exp_rdy = !(mv0 && mv1) || r;
         checks++; if (valid_o !== mv1) begin errors++; $display("FAIL bp_valid cyc %0d got %b exp %b", cyc, valid_o, mv1); end
         checks++; if (ready_o !== exp_rdy) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp %b", cyc, ready_o, exp_rdy); end
         if (mv1) begin
            checks++; if (data_o !== md1) begin errors++; $display("FAIL bp_data cyc %0d got %h exp %h", cyc, data_o, md1); end
            checks++; if (id_o !== md1[1:0]) begin errors++; $display("FAIL bp_id cyc %0d got %0d exp %0d", cyc, id_o, md1[1:0]); end
         end
         if (mv1 && r) begin
            checks++; if (md1 !== rcvd[7:0]) begin errors++; $display("FAIL bp_order got %h exp %h", md1, rcvd[7:0]); end
            rcvd++;
         end
         adv1 = !mv1 || r;
         adv0 = !mv0 || adv1;
         if (valid_i && exp_rdy) sent++;
         if (adv1) begin mv1 = mv0; if (mv0) md1 = md0; end
         if (adv0) begin mv0 = valid_i; if (valid_i) md0 = data_i; end
         @(negedge clk_i);
      end
      valid_i = 1'b0; ready_i = 1'b1;
      checks++; if (rcvd !== 16) begin errors++; $display("FAIL bp_count got %0d exp 16", rcvd); end
      repeat (3) @(negedge clk_i);
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_dup got %b exp 0", valid_o); end
   endtask

   task automatic test_throughput();
      int beats;
      int expd;
      beats = 0; expd = 0;
      ready_i = 1'b1; inject_fault_i = 1'b0;
      for (int k = 0; k < 100; k++) begin
         valid_i = 1'b1;
         data_i  = k[7:0];
         id_i    = k[1:0];
         @(negedge clk_i);
         if (valid_o) begin
            checks++; if (data_o !== expd[7:0]) begin errors++; $display("FAIL tp_data got %h exp %h", data_o, expd[7:0]); end
            expd++;
            beats++;
         end
         if (ready_o !== 1'b1) begin
            checks++; errors++; $display("FAIL tp_ready at %0d got 0 exp 1", k);
         end
      end
      valid_i = 1'b0;
      checks++; if (beats !== 100 - DEPTH + 1) begin errors++; $display("FAIL tp_beats got %0d exp %0d", beats, 100 - DEPTH + 1); end
      repeat (3) @(negedge clk_i);
   endtask

   task automatic test_saturation();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         valid_i = 1'b1; inject_fault_i = 1'b1; data_i = 8'h40 + k[7:0]; id_i = k[1:0];
         @(negedge clk_i);
         if (valid_o) begin
            checks++; if (faulty_o !== 1'b1) begin errors++; $display("FAIL sat_faulty got %b exp 1", faulty_o); end
         end
      end
      valid_i = 1'b0; inject_fault_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++; if (sat_fault_cnt_o !== 2'd3) begin errors++; $display("FAIL sat_cnt got %0d exp 3", sat_fault_cnt_o); end
      checks++; if (fault_cnt_o !== 16'd5) begin errors++; $display("FAIL wide_cnt got %0d exp 5", fault_cnt_o); end
      valid_i = 1'b1; inject_fault_i = 1'b1; data_i = 8'h77;
      @(negedge clk_i);
      valid_i = 1'b0; inject_fault_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++; if (sat_fault_cnt_o !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", sat_fault_cnt_o); end
      checks++; if (fault_cnt_o !== 16'd6) begin errors++; $display("FAIL wide_cnt6 got %0d exp 6", fault_cnt_o); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_latency();
      test_injection();
      test_backpressure();
      test_throughput();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/retry_dmr_stage.md
Name: retry_dmr_stage

Overview:
- Dual-modular-redundant pipelined processing stage between retry_start (upstream) and retry_end (downstream).
- Carries every beat (data + id) through two independent register copies (A and B) for DEPTH stages.
- Compares the copies at the output and drives faulty_o to retry_end, which triggers a retry of that id.
- Provides a fault-injection input and a saturating fault counter for bring-up and test.

Parameters:
- DataType, logic [7:0], payload type; carried in both copies.
- ID_SIZE, 2, width of the retry id; matches retry_start/retry_end.
- DEPTH, 2, number of pipeline stages (>=1).
- CntWidth, 16, width of the fault counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock domain, reset is asynchronous and active-low
- data_i  in  DataType  payload from retry_start
- id_i  in  ID_SIZE  retry id from retry_start
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- inject_fault_i  in  1  when high at the input handshake, bit 0 of copy-B data is inverted
- data_o  out  DataType  copy-A payload of the output stage
- id_o  out  ID_SIZE  copy-A id of the output stage
- faulty_o  out  1  copy mismatch at the output stage
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- fault_cnt_o  out  CntWidth  number of faulty beats handed downstream (saturating)

Behaviour:
- Reset (async assert, synchronous release on clk_i): all stage valids = 0; A/B data and id = 0; fault_cnt_o = 0.
  - Outputs in reset: valid_o = 0, faulty_o = 0, data_o = 0, id_o = 0, ready_o = 1.
  - Reset mid-operation drops all in-flight beats without emitting them.
- Stage s holds valid[s] (single, shared by both copies), data_a/b[s] and id_a/b[s]. Stage 0 is the input stage; stage DEPTH-1 drives the outputs.
- Advance rules:
  - Output stage: adv[DEPTH-1] = !valid[DEPTH-1] || ready_i.
  - Other stages: adv[s] = !valid[s] || adv[s+1].
  - ready_o = adv[0].
  - Stage s loads from stage s-1 (or from the inputs, for s=0) when adv[s] is high.
  - On load, valid[s] takes the previous stage's valid (or valid_i). Data/id registers load only when the incoming valid is 1; otherwise they hold.
- Throughput and latency:
  - Full throughput: one beat per cycle with ready_i held high.
  - Latency is DEPTH cycles from the input handshake to valid_o.
- Bubbles are collapsed: an empty stage accepts even while downstream is stalled.
- Input capture on handshake (valid_i && ready_o):
  - data_a = data_i, data_b = data_i ^ inject_fault_i (bit 0 only).
  - id_a = id_b = id_i.
- Copies A and B never share a register. No combinational path exists from copy A to copy B.
- faulty_o = valid[DEPTH-1] && ((data_a != data_b) || (id_a != id_b)) at the output stage. It is 0 whenever valid_o = 0.
- valid_o/data_o/id_o/faulty_o come straight from output-stage registers plus the compare. No input-to-output combinational path exists except ready_i -> ready_o.
- Held stable while valid_o && !ready_i: data_o, id_o, faulty_o.
- fault_cnt_o increments by 1 on each output handshake with faulty_o = 1 and saturates at all-ones. It does not wrap.
- Simultaneous input and output handshakes in the same cycle are legal at every stage. No beat is lost or duplicated.
- Ordering: strictly FIFO. Ids pass through unchanged on copy A.

Decomposition:
- No new package typedefs; DataType and ID_SIZE come from the instantiating level, as for retry_start/retry_end.
- One sub-module: retry_dmr_pipe_reg. It is a single elastic stage (valid, A/B data and id, adv in/out), instantiated DEPTH times in a generate loop.
- Compare, counter and injection logic stay in the top.

Test Plan:
- Reset: hold rst_ni = 0 for 10 cycles, then release -> valid_o = 0, ready_o = 1, fault_cnt_o = 0. Assert rst_ni with 2 beats in flight -> no beats emitted after release.
- Latency: DEPTH = 2, ready_i = 1, send data 8'hA5 with id 2'd1 -> 2 cycles later valid_o = 1, data_o = 8'hA5, id_o = 1, faulty_o = 0.
- Injection: send 8'h3C with inject_fault_i = 1 -> output beat has data_o = 8'h3C, faulty_o = 1, and fault_cnt_o becomes 1 after the handshake.
- Backpressure: stream 8'h00..8'h0F with ready_i random at 50%.
  - Output order exactly 00..0F, no drops or duplicates.
  - Outputs stable while stalled.
  - ready_o low only when all DEPTH stages are full and ready_i = 0.
- Throughput: ready_i = 1 and valid_i = 1 for 100 cycles -> 100 - DEPTH + 1 beats out within that window, one per cycle after fill.
- Saturation: CntWidth = 2, inject 5 faulty beats -> fault_cnt_o = 3 and stays 3. Closed-loop run with retry_start/retry_end and random injection -> the sink receives every payload in order.
